rob_retire: RTL and testbench

- In-order commit stage directly downstream of the reorder buffer.
- Each cycle it inspects the ROB head window and retires the longest legal prefix of completed entries, up to EXT_COUNT per cycle.
- For retired entries it writes results to the architectural register file, performs committed stores through a request/ack handshake, and raises a pipeline flush on excepting entries.
- It drives the ROB's consume interface.

---
 rtl/rob_retire_pkg.sv | 25 ++
 rtl/rob_retire_select.sv | 58 +++++
 rtl/rob_retire.sv | 170 +++++++++++++++++
 tb/tb_rob_retire.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_pkg.sv
// Shared types for the in-order commit stage: ROB entry layout, retire FSM
// states and the classification of the ROB head slot.
package rob_retire_pkg;

   typedef struct packed {
      logic [31:0] result_lo;
      logic [4:0]  dest_reg;
      logic        dest_reg_valid;
      logic        is_store;
      logic [31:0] mem_addr;
      logic [31:0] store_data;
      logic        exc;
      logic [31:0] pc;
   } rob_entry_t;

   typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} retire_state_t;

   typedef enum logic [1:0] {SLOT_NONE, SLOT_ORD, SLOT_STORE, SLOT_EXC} slot_class_t;

   // r0 is hardwired, so an entry only writes back when it names a real register.
   function automatic logic writes_reg(input rob_entry_t e);
      return e.dest_reg_valid && (e.dest_reg != 5'd0);
   endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Combinational scan of the ROB head window: finds the longest prefix of
// completed ordinary entries and classifies the oldest slot.
module rob_retire_select
   import rob_retire_pkg::*;
#(
   parameter int EXT_COUNT = 2,
   parameter int DEPTHLOG2 = 4,
   parameter int NW        = $clog2(EXT_COUNT + 1)
) (
   input  rob_entry_t [EXT_COUNT-1:0] slot_data,
   input  logic [EXT_COUNT-1:0]       slot_valid,
   input  logic [DEPTHLOG2:0]         used_count,
   output logic [EXT_COUNT-1:0]       selected,
   output logic [NW-1:0]              n,
   output slot_class_t                slot0_class
);

   localparam logic [NW-1:0] ONE = 1;

   logic [EXT_COUNT-1:0] eligible;
   logic [EXT_COUNT-1:0] ordinary;
   logic                 open;

   generate
      for (genvar gi = 0; gi < EXT_COUNT; gi++) begin : g_slot
         assign eligible[gi] = slot_valid[gi] && ((DEPTHLOG2+1)'(gi) < used_count);
         assign ordinary[gi] = eligible[gi] && !slot_data[gi].is_store && !slot_data[gi].exc;
      end
   endgenerate

   // The first non-ordinary slot closes the prefix; nothing younger may pass it.
   always_comb begin
      selected = '0;
      n        = '0;
      open     = 1'b1;
      for (int i = 0; i < EXT_COUNT; i++) begin
         if (open && ordinary[i]) begin
            selected[i] = 1'b1;
            n           = n + ONE;
         end else begin
            open = 1'b0;
         end
      end
   end

   always_comb begin
      slot0_class = SLOT_NONE;
      if (eligible[0]) begin
         if (slot_data[0].exc)
            slot0_class = SLOT_EXC;
         else if (slot_data[0].is_store)
            slot0_class = SLOT_STORE;
         else
            slot0_class = SLOT_ORD;
      end
   end

endmodule

// File: rtl/rob_retire.sv
// In-order commit stage: retires the head prefix of the ROB, writes the
// register file, issues committed stores and raises flushes on exceptions.
module rob_retire
   import rob_retire_pkg::*;
#(
   parameter int EXT_COUNT    = 2,
   parameter int DEPTH        = 16,
   parameter int DEPTHLOG2    = $clog2(DEPTH),
   parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  rob_entry_t [EXT_COUNT-1:0]    slot_data,
   input  logic [EXT_COUNT-1:0]          slot_valid,
   input  logic [DEPTHLOG2:0]            used_count,
   output logic                          consume,
   output logic [EXTCOUNTLOG2-1:0]       consume_count,
   output logic [EXT_COUNT-1:0]          rf_we,
   output logic [EXT_COUNT-1:0][4:0]     rf_waddr,
   output logic [EXT_COUNT-1:0][31:0]    rf_wdata,
   output logic                          st_req,
   output logic [31:0]                   st_addr,
   output logic [31:0]                   st_data,
   input  logic                          st_ack,
   output logic                          flush,
   output logic [31:0]                   flush_pc,
   output logic [31:0]                   retired_count
);

   localparam int NW = $clog2(EXT_COUNT + 1);
   localparam logic [NW-1:0] ONE = 1;

   retire_state_t state_reg, state_next;
   logic          st_req_reg, st_req_next;
   logic [31:0]   st_addr_reg, st_addr_next;
   logic [31:0]   st_data_reg, st_data_next;
   logic          flush_reg, flush_next;
   logic [31:0]   flush_pc_reg, flush_pc_next;
   logic [31:0]   retired_reg, retired_next;

   logic [EXT_COUNT-1:0] selected;
   logic [EXT_COUNT-1:0] we_cand;
   logic [EXT_COUNT-1:0] we_final;
   logic [EXT_COUNT-1:0] we_raw;
   logic [NW-1:0]        sel_n;
   logic [NW-1:0]        retire_n;
   logic                 consume_raw;
   slot_class_t          slot0_class;
   logic                 unused_slot_bits;

   rob_retire_select #(
      .EXT_COUNT (EXT_COUNT),
      .DEPTHLOG2 (DEPTHLOG2),
      .NW        (NW)
   ) u_select (
      .slot_data   (slot_data),
      .slot_valid  (slot_valid),
      .used_count  (used_count),
      .selected    (selected),
      .n           (sel_n),
      .slot0_class (slot0_class)
   );

   generate
      for (genvar gi = 0; gi < EXT_COUNT; gi++) begin : g_rf
         assign we_cand[gi]  = selected[gi] && writes_reg(slot_data[gi]);
         assign rf_waddr[gi] = reset_n ? slot_data[gi].dest_reg  : 5'd0;
         assign rf_wdata[gi] = reset_n ? slot_data[gi].result_lo : 32'd0;
      end
   endgenerate

   // A younger write to the same register in this group masks the older one,
   // so the result never depends on register-file port priority.
   always_comb begin
      we_final = we_cand;
      for (int i = 0; i < EXT_COUNT; i++) begin
         for (int j = i + 1; j < EXT_COUNT; j++) begin
            if (we_cand[j] && (slot_data[j].dest_reg == slot_data[i].dest_reg))
               we_final[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      st_req_next   = st_req_reg;
      st_addr_next  = st_addr_reg;
      st_data_next  = st_data_reg;
      flush_next    = 1'b0;
      flush_pc_next = flush_pc_reg;
      consume_raw   = 1'b0;
      retire_n      = '0;
      we_raw        = '0;
      case (state_reg)
         RUN: begin
            case (slot0_class)
               SLOT_STORE: begin
                  st_req_next  = 1'b1;
                  st_addr_next = slot_data[0].mem_addr;
                  st_data_next = slot_data[0].store_data;
                  state_next   = ST_WAIT;
               end
               SLOT_EXC: begin
                  consume_raw   = 1'b1;
                  retire_n      = ONE;
                  flush_next    = 1'b1;
                  flush_pc_next = slot_data[0].pc;
                  state_next    = FLUSH;
               end
               default: begin
                  if (sel_n != '0) begin
                     consume_raw = 1'b1;
                     retire_n    = sel_n;
                     we_raw      = we_final;
                  end
               end
            endcase
         end
         ST_WAIT: begin
            if (st_ack && st_req_reg) begin
               consume_raw = 1'b1;
               retire_n    = ONE;
               st_req_next = 1'b0;
               state_next  = RUN;
            end
         end
         FLUSH:   state_next = RUN;
         default: state_next = RUN;
      endcase
      retired_next = retired_reg + 32'(retire_n);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg    <= RUN;
         st_req_reg   <= 1'b0;
         st_addr_reg  <= 32'd0;
         st_data_reg  <= 32'd0;
         flush_reg    <= 1'b0;
         flush_pc_reg <= 32'd0;
         retired_reg  <= 32'd0;
      end else begin
         state_reg    <= state_next;
         st_req_reg   <= st_req_next;
         st_addr_reg  <= st_addr_next;
         st_data_reg  <= st_data_next;
         flush_reg    <= flush_next;
         flush_pc_reg <= flush_pc_next;
         retired_reg  <= retired_next;
      end
   end

   // Store/exception fields of younger slots are only acted on once they reach the head.
   always_comb begin
      unused_slot_bits = 1'b0;
      for (int i = 1; i < EXT_COUNT; i++)
         unused_slot_bits = unused_slot_bits ^ (^{slot_data[i].mem_addr, slot_data[i].store_data, slot_data[i].pc});
   end

   assign consume       = reset_n && consume_raw;
   assign consume_count = consume ? EXTCOUNTLOG2'(retire_n - ONE) : '0;
   assign rf_we         = reset_n ? we_raw : '0;
   assign st_req        = st_req_reg;
   assign st_addr       = st_addr_reg;
   assign st_data       = st_data_reg;
   assign flush         = flush_reg;
   assign flush_pc      = flush_pc_reg;
   assign retired_count = retired_reg;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a queue-free behavioural model checks every
// cycle, while literal checks pin the expected values of each scenario.
module tb_rob_retire;
   import rob_retire_pkg::*;

   localparam int EXT = 2;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   rob_entry_t [EXT-1:0]   slot_data;
   logic [EXT-1:0]         slot_valid;
   logic [4:0]             used_count;
   logic                   consume;
   logic [0:0]             consume_count;
   logic [EXT-1:0]         rf_we;
   logic [EXT-1:0][4:0]    rf_waddr;
   logic [EXT-1:0][31:0]   rf_wdata;
   logic                   st_req;
   logic [31:0]            st_addr;
   logic [31:0]            st_data;
   logic                   st_ack;
   logic                   flush;
   logic [31:0]            flush_pc;
   logic [31:0]            retired_count;

   rob_retire #(.EXT_COUNT(EXT), .DEPTH(16)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .slot_data     (slot_data),
      .slot_valid    (slot_valid),
      .used_count    (used_count),
      .consume       (consume),
      .consume_count (consume_count),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .st_req        (st_req),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_ack        (st_ack),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .retired_count (retired_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_live = 1'b0;
   bit          m_store = 1'b0, nx_store = 1'b0;
   bit          m_flush = 1'b0, nx_flush = 1'b0;
   logic [31:0] m_addr = '0, nx_addr = '0;
   logic [31:0] m_data = '0, nx_data = '0;
   logic [31:0] m_fpc = '0, nx_fpc = '0;
   logic [31:0] m_cnt = '0, nx_cnt = '0;

   always @(negedge clock) begin : model_compare
      int          k;
      int          exp_n;
      bit          exp_consume;
      logic [1:0]  exp_we;
      bit [31:0]   claimed;
      bit          head_ok;
      exp_n = 0; exp_consume = 1'b0; exp_we = '0; claimed = '0;
      nx_store = m_store; nx_addr = m_addr; nx_data = m_data;
      nx_flush = 1'b0; nx_fpc = m_fpc;
      if (!reset_n) begin
         nx_store = 1'b0; nx_addr = '0; nx_data = '0; nx_fpc = '0;
      end else if (m_flush) begin
         exp_consume = 1'b0;
      end else if (m_store) begin
         if (st_ack) begin
            exp_consume = 1'b1; exp_n = 1; nx_store = 1'b0;
         end
      end else begin
         k = 0;
         while (k < EXT && k < int'(used_count) && slot_valid[k] &&
                !slot_data[k].is_store && !slot_data[k].exc)
            k++;
         head_ok = (used_count > 0) && slot_valid[0];
         if (k == 0 && head_ok && slot_data[0].exc) begin
            exp_consume = 1'b1; exp_n = 1; nx_flush = 1'b1; nx_fpc = slot_data[0].pc;
         end else if (k == 0 && head_ok && slot_data[0].is_store) begin
            nx_store = 1'b1; nx_addr = slot_data[0].mem_addr; nx_data = slot_data[0].store_data;
         end else if (k > 0) begin
            exp_consume = 1'b1; exp_n = k;
            for (int i = k - 1; i >= 0; i--) begin
               if (slot_data[i].dest_reg_valid && slot_data[i].dest_reg != 0 &&
                   !claimed[slot_data[i].dest_reg]) begin
                  exp_we[i] = 1'b1;
                  claimed[slot_data[i].dest_reg] = 1'b1;
               end
            end
         end
      end
      nx_cnt = reset_n ? m_cnt + 32'(exp_n) : 32'd0;

      if (m_live) begin
         chk("m.consume", consume, exp_consume);
         if (exp_consume) chk("m.consume_count", consume_count, 64'(exp_n - 1));
         chk("m.rf_we", rf_we, exp_we);
         for (int i = 0; i < EXT; i++) begin
            if (exp_we[i]) begin
               chk("m.rf_waddr", rf_waddr[i], slot_data[i].dest_reg);
               chk("m.rf_wdata", rf_wdata[i], slot_data[i].result_lo);
            end
         end
         chk("m.st_req", st_req, m_store);
         if (m_store) begin
            chk("m.st_addr", st_addr, m_addr);
            chk("m.st_data", st_data, m_data);
         end
         chk("m.flush", flush, m_flush);
         if (m_flush) chk("m.flush_pc", flush_pc, m_fpc);
         chk("m.retired_count", retired_count, m_cnt);
      end
   end

   always @(posedge clock) begin
      m_live  <= 1'b1;
      m_store <= nx_store;
      m_addr  <= nx_addr;
      m_data  <= nx_data;
      m_flush <= nx_flush;
      m_fpc   <= nx_fpc;
      m_cnt   <= nx_cnt;
   end

   // ---------------- stimulus ----------------
   function automatic rob_entry_t alu(input logic [4:0] d, input logic [31:0] r);
      rob_entry_t e = '0;
      e.dest_reg = d; e.dest_reg_valid = 1'b1; e.result_lo = r;
      return e;
   endfunction

   function automatic rob_entry_t st_e(input logic [31:0] a, input logic [31:0] d);
      rob_entry_t e = '0;
      e.is_store = 1'b1; e.mem_addr = a; e.store_data = d;
      return e;
   endfunction

   function automatic rob_entry_t exc_e(input logic [31:0] pc);
      rob_entry_t e = '0;
      e.exc = 1'b1; e.pc = pc;
      return e;
   endfunction

   task automatic drive(input string name, input rob_entry_t e0, input rob_entry_t e1,
                        input logic [1:0] v, input logic [4:0] used, input logic ack);
      @(posedge clock);
      #1;
      slot_data[0] = e0; slot_data[1] = e1;
      slot_valid = v; used_count = used; st_ack = ack;
      #1;
      $display("step %s: consume=%0b cc=%0d rf_we=%b st_req=%0b flush=%0b retired=%0d",
               name, consume, consume_count, rf_we, st_req, flush, retired_count);
   endtask

   initial begin
      slot_data = '0; slot_valid = '0; used_count = '0; st_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      chk("reset.retired_count", retired_count, 0);
      chk("reset.st_req", st_req, 0);
      chk("reset.flush", flush, 0);
      chk("reset.consume", consume, 0);

      drive("two_alu", alu(3, 32'h11), alu(5, 32'h22), 2'b11, 5'd2, 1'b0);
      chk("two_alu.consume", consume, 1);
      chk("two_alu.cc", consume_count, 1);
      chk("two_alu.rf_we", rf_we, 2'b11);
      chk("two_alu.waddr0", rf_waddr[0], 3);
      chk("two_alu.waddr1", rf_waddr[1], 5);

      drive("slot1_invalid", alu(6, 32'h33), alu(9, 32'h44), 2'b01, 5'd2, 1'b0);
      chk("two_alu.retired", retired_count, 2);
      chk("slot1_invalid.cc", consume_count, 0);
      chk("slot1_invalid.rf_we", rf_we, 2'b01);

      drive("store_issue", st_e(32'h100, 32'hDEADBEEF), '0, 2'b01, 5'd1, 1'b0);
      chk("store_issue.consume", consume, 0);
      chk("store_issue.retired", retired_count, 3);
      drive("store_wait1", st_e(32'h100, 32'hDEADBEEF), '0, 2'b01, 5'd1, 1'b0);
      chk("store_wait1.st_req", st_req, 1);
      chk("store_wait1.st_addr", st_addr, 32'h100);
      chk("store_wait1.st_data", st_data, 32'hDEADBEEF);
      chk("store_wait1.consume", consume, 0);
      drive("store_wait2", st_e(32'h100, 32'hDEADBEEF), '0, 2'b01, 5'd1, 1'b0);
      chk("store_wait2.st_req", st_req, 1);
      chk("store_wait2.consume", consume, 0);
      drive("store_ack", st_e(32'h100, 32'hDEADBEEF), '0, 2'b01, 5'd1, 1'b1);
      chk("store_ack.st_req", st_req, 1);
      chk("store_ack.consume", consume, 1);
      chk("store_ack.cc", consume_count, 0);

      drive("alu_then_exc", alu(4, 32'h55), exc_e(32'h400), 2'b11, 5'd2, 1'b0);
      chk("alu_then_exc.st_req", st_req, 0);
      chk("alu_then_exc.retired", retired_count, 4);
      chk("alu_then_exc.consume", consume, 1);
      chk("alu_then_exc.cc", consume_count, 0);
      chk("alu_then_exc.rf_we", rf_we, 2'b01);
      drive("exc_head", exc_e(32'h400), '0, 2'b01, 5'd1, 1'b0);
      chk("exc_head.consume", consume, 1);
      chk("exc_head.rf_we", rf_we, 2'b00);
      chk("exc_head.retired", retired_count, 5);
      drive("flush_cycle", '0, '0, 2'b00, 5'd0, 1'b0);
      chk("flush_cycle.flush", flush, 1);
      chk("flush_cycle.flush_pc", flush_pc, 32'h400);
      chk("flush_cycle.consume", consume, 0);
      chk("flush_cycle.retired", retired_count, 6);

      drive("same_r7", alu(7, 32'hAAAA), alu(7, 32'hBBBB), 2'b11, 5'd2, 1'b0);
      chk("same_r7.flush", flush, 0);
      chk("same_r7.rf_we", rf_we, 2'b10);
      chk("same_r7.waddr1", rf_waddr[1], 7);
      chk("same_r7.wdata1", rf_wdata[1], 32'hBBBB);
      drive("both_r0", alu(0, 32'h1), alu(0, 32'h2), 2'b11, 5'd2, 1'b0);
      chk("both_r0.rf_we", rf_we, 2'b00);
      chk("both_r0.cc", consume_count, 1);
      chk("both_r0.consume", consume, 1);
      chk("both_r0.retired", retired_count, 8);

      drive("empty_rob", alu(1, 32'h1), alu(2, 32'h2), 2'b11, 5'd0, 1'b0);
      chk("empty_rob.consume", consume, 0);
      chk("empty_rob.rf_we", rf_we, 2'b00);
      chk("empty_rob.retired", retired_count, 10);
      drive("used_one", alu(1, 32'h1), alu(2, 32'h2), 2'b11, 5'd1, 1'b0);
      chk("used_one.consume", consume, 1);
      chk("used_one.cc", consume_count, 0);
      chk("used_one.rf_we", rf_we, 2'b01);

      drive("store2_issue", st_e(32'h200, 32'h12345678), '0, 2'b01, 5'd1, 1'b0);
      chk("store2_issue.retired", retired_count, 11);
      drive("store2_wait", st_e(32'h200, 32'h12345678), '0, 2'b01, 5'd1, 1'b0);
      chk("store2_wait.st_req", st_req, 1);

      @(posedge clock);
      #1;
      reset_n = 1'b0; st_ack = 1'b1;
      #1;
      $display("step reset_in_wait: consume=%0b st_req=%0b", consume, st_req);
      chk("reset_in_wait.consume", consume, 0);
      chk("reset_in_wait.rf_we", rf_we, 2'b00);

      @(posedge clock);
      #1;
      reset_n = 1'b1; slot_valid = '0; used_count = '0; st_ack = 1'b1;
      #1;
      $display("step after_reset: consume=%0b st_req=%0b retired=%0d", consume, st_req, retired_count);
      chk("after_reset.st_req", st_req, 0);
      chk("after_reset.retired", retired_count, 0);
      chk("after_reset.consume", consume, 0);
      drive("late_ack", '0, '0, 2'b00, 5'd0, 1'b1);
      chk("late_ack.consume", consume, 0);
      chk("late_ack.st_req", st_req, 0);
      drive("run_again", alu(2, 32'h77), '0, 2'b01, 5'd1, 1'b0);
      chk("run_again.consume", consume, 1);
      chk("run_again.rf_we", rf_we, 2'b01);
      drive("idle", '0, '0, 2'b00, 5'd0, 1'b0);
      chk("idle.retired", retired_count, 1);

      @(posedge clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
